// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the Memory-stage
// pipeline port and a DMA/debug-loader port. The pipeline has priority; after
// STARVE_MAX consecutive conflict cycles the DMA port gets a forced slot and
// the pipeline is stalled for that cycle.
// Optional feature macro: DMEM_ARB_LOCK_EN adds the d_lock burst-lock port,
// which lets the DMA hold the memory for up to LOCK_MAX consecutive cycles.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned LOCK_MAX   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W-1:0] m_rdata,
  output logic              stall_o,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              d_lock,
`endif
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [0:0] {
    ST_PIPE = 1'b0,
    ST_DMA  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               rvalid_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               dma_sel;

`ifdef DMEM_ARB_LOCK_EN
  logic [LOCK_W-1:0]  lock_q, lock_d;
`else
  logic [LOCK_W-1:0]  unused_lock_cnt;
  assign unused_lock_cnt = '0;
`endif

  // Next-state, starvation counting and DMA select
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    dma_sel  = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    lock_d   = lock_q;
`endif
    case (state_q)
      ST_PIPE: begin
`ifdef DMEM_ARB_LOCK_EN
        lock_d = '0;
`endif
        if (d_req && !m_req) begin
          dma_sel  = 1'b1;
          starve_d = '0;
        end else if (d_req && m_req) begin
          if (starve_q >= CNT_W'(STARVE_MAX - 1)) begin
            state_d  = ST_DMA;
            starve_d = '0;
          end else begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else begin
          starve_d = '0;
        end
      end
      ST_DMA: begin
        dma_sel  = d_req;
        state_d  = ST_PIPE;
        starve_d = '0;
`ifdef DMEM_ARB_LOCK_EN
        if (d_req && d_lock && (lock_q != LOCK_W'(LOCK_MAX - 1))) begin
          state_d = ST_DMA;
          lock_d  = lock_q + LOCK_W'(1);
        end else begin
          lock_d  = '0;
        end
`endif
      end
      default: begin
        state_d  = ST_PIPE;
        starve_d = '0;
      end
    endcase
  end

  // Memory-side mux; grants and writes are suppressed while reset is low
  always_comb begin
    d_gnt   = reset & dma_sel;
    stall_o = m_req & d_gnt;
    mem_we  = reset & (dma_sel ? d_we : (m_req & m_we));
    mem_a   = dma_sel ? d_addr  : m_addr;
    mem_wd  = dma_sel ? d_wdata : m_wdata;
    m_rdata = mem_rd;
  end

  assign d_rvalid = rvalid_q;
  assign d_rdata  = rdata_q;

  // State, counters and registered DMA read return
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_PIPE;
      starve_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
`ifdef DMEM_ARB_LOCK_EN
      lock_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rvalid_q <= dma_sel & ~d_we;
      if (dma_sel && !d_we) begin
        rdata_q <= mem_rd;
      end
`ifdef DMEM_ARB_LOCK_EN
      lock_q   <= lock_d;
`endif
    end
  end

endmodule
